// File: rtl/exception_unit_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
// Shared definitions for the exception/trap controller: the controller state
// encoding, the fixed cause indices used by the control unit and the size of
// one vector table entry.
// -----------------------------------------------------------------------------
package exc_pkg;

  // Controller states, in the order a trap walks through them.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT     = 3'd2,
    DISPATCH = 3'd3,
    HANDLER  = 3'd4,
    RETURN   = 3'd5
  } exc_state_t;

  // Cause indices raised by the control unit (lower index = higher priority).
  localparam int CAUSE_OPCODE   = 32'd0;
  localparam int CAUSE_OVERFLOW = 32'd1;

  // One handler address per cause, one word per entry.
  localparam int VEC_ENTRY_BYTES = 32'd4;

endpackage

// File: rtl/exception_unit_if.sv
// -----------------------------------------------------------------------------
// exception_unit_if
// Vector-table read bus between the exception unit and memory.
//   vec_rd_req   : read request, held until the data strobe arrives
//   vec_addr     : byte address of the vector entry, stable with vec_rd_req
//   vec_rd_valid : one-cycle read-data strobe from memory
//   vec_rd_data  : handler address read from the table
// master = exception unit, slave = memory.
// -----------------------------------------------------------------------------
interface exception_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             vec_rd_req;
  logic [WIDTH-1:0] vec_addr;
  logic             vec_rd_valid;
  logic [WIDTH-1:0] vec_rd_data;

  modport master (
    output vec_rd_req,
    output vec_addr,
    input  vec_rd_valid,
    input  vec_rd_data
  );

  modport slave (
    input  vec_rd_req,
    input  vec_addr,
    output vec_rd_valid,
    output vec_rd_data
  );

endinterface

// File: rtl/exception_unit_prio_enc.sv
// -----------------------------------------------------------------------------
// exc_prio_enc
// Combinational fixed-priority encoder; bit 0 wins.
//   i_req   : request vector
//   o_valid : any request set
//   o_index : index of the lowest set request
//   o_clear : one-hot mask of that request
// -----------------------------------------------------------------------------
module exc_prio_enc #(
  parameter int NUM_CAUSES = 4
) (
  input  logic [NUM_CAUSES-1:0]         i_req,
  output logic                          o_valid,
  output logic [$clog2(NUM_CAUSES)-1:0] o_index,
  output logic [NUM_CAUSES-1:0]         o_clear
);

  localparam int IDX_W = $clog2(NUM_CAUSES);

  assign o_valid = |i_req;

  // x & ~(x-1) isolates the lowest set bit; zero in gives zero out.
  assign o_clear = i_req & ~(i_req - NUM_CAUSES'(1));

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_index = '0;
    for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
      o_index = i_req[i] ? IDX_W'(i) : o_index;
    end
  end

endmodule

// File: rtl/exception_unit.sv
// -----------------------------------------------------------------------------
// exception_unit
// Prioritised exception/trap controller for the multicycle MIPS core.
// Accepts the highest-priority cause, saves EPC/Cause, reads the handler
// address from a word-per-cause vector table and redirects the PC. Causes
// arriving while a handler runs are queued and serviced on eret.
// Ports:
//   i_clock, i_reset    : clock, synchronous active-high reset
//   i_cause_req         : one-cycle cause pulses, bit 0 highest priority
//   i_fault_pc          : faulting PC, sampled when a cause is accepted
//   i_eret              : return-from-exception pulse (honoured in HANDLER)
//   vec_bus             : vector-table read bus (master side)
//   o_trap_pc/_valid    : handler address and one-cycle load strobe
//   o_ret_pc_valid      : one-cycle strobe to load the PC from o_epc
//   o_epc, o_cause      : saved faulting PC and serviced cause index
//   o_in_handler        : handler episode in progress
//   o_stall             : freeze the control unit (FETCH/WAIT/DISPATCH)
// -----------------------------------------------------------------------------
module exception_unit
  import exc_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          NUM_CAUSES  = 4,
  parameter int unsigned VECTOR_BASE = 32'd240
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NUM_CAUSES-1:0] i_cause_req,
  input  logic [WIDTH-1:0]      i_fault_pc,
  input  logic                  i_eret,
  exception_unit_if.master      vec_bus,
  output logic [WIDTH-1:0]      o_trap_pc,
  output logic                  o_trap_pc_valid,
  output logic                  o_ret_pc_valid,
  output logic [WIDTH-1:0]      o_epc,
  output logic [WIDTH-1:0]      o_cause,
  output logic                  o_in_handler,
  output logic                  o_stall
);

  localparam int IDX_W = $clog2(NUM_CAUSES);

  exc_state_t              r_state;
  exc_state_t              w_state_nxt;
  logic [NUM_CAUSES-1:0]   r_pending;
  logic [NUM_CAUSES-1:0]   w_req;
  logic [NUM_CAUSES-1:0]   w_clear;
  logic [NUM_CAUSES-1:0]   w_pending_nxt;
  logic                    w_valid;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_accept;
  logic                    w_rd_done;
  logic [WIDTH-1:0]        w_vec_addr;

  logic [WIDTH-1:0]        r_epc;
  logic [WIDTH-1:0]        r_cause;
  logic [WIDTH-1:0]        r_trap_pc;
  logic [WIDTH-1:0]        r_vec_addr;
  logic                    r_vec_rd_req;
  logic                    r_trap_pc_valid;
  logic                    r_ret_pc_valid;
  logic                    r_in_handler;
  logic                    r_stall;

  // A request pulse competes in the same cycle it arrives (0-cycle accept).
  assign w_req = r_pending | i_cause_req;

  exc_prio_enc #(
    .NUM_CAUSES (NUM_CAUSES)
  ) u_prio_enc (
    .i_req   (w_req),
    .o_valid (w_valid),
    .o_index (w_idx),
    .o_clear (w_clear)
  );

  // Data strobe in FETCH is taken exactly as in WAIT; elsewhere it is stale.
  assign w_rd_done  = ((r_state == FETCH) || (r_state == WAIT)) && vec_bus.vec_rd_valid;
  // Wraps modulo 2^WIDTH by construction.
  assign w_vec_addr = WIDTH'(VECTOR_BASE) + (WIDTH'(VEC_ENTRY_BYTES) * WIDTH'(w_idx));
  assign w_pending_nxt = w_req & ~(w_accept ? w_clear : {NUM_CAUSES{1'b0}});

  // Next-state decode and acceptance decision.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FETCH: begin
        if (w_rd_done) begin
          w_state_nxt = DISPATCH;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_rd_done) begin
          w_state_nxt = DISPATCH;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      DISPATCH: begin
        w_state_nxt = HANDLER;
      end
      HANDLER: begin
        if (i_eret) begin
          w_state_nxt = RETURN;
        end else begin
          w_state_nxt = HANDLER;
        end
      end
      RETURN: begin
        // Queued work re-enters without an IDLE bubble; i_fault_pc then
        // carries the return target so the new EPC is correct.
        if (w_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, pending causes and the captured trap context.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_epc      <= '0;
      r_cause    <= '0;
      r_vec_addr <= '0;
      r_trap_pc  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      if (w_accept) begin
        r_epc      <= i_fault_pc;
        r_cause    <= WIDTH'(w_idx);
        r_vec_addr <= w_vec_addr;
      end
      if (w_rd_done) begin
        r_trap_pc <= vec_bus.vec_rd_data;
      end
    end
  end

  // Strobes and status flags registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_vec_rd_req    <= 1'b0;
      r_trap_pc_valid <= 1'b0;
      r_ret_pc_valid  <= 1'b0;
      r_in_handler    <= 1'b0;
      r_stall         <= 1'b0;
    end else begin
      r_vec_rd_req    <= (w_state_nxt == FETCH) || (w_state_nxt == WAIT);
      r_trap_pc_valid <= (w_state_nxt == DISPATCH);
      r_ret_pc_valid  <= (w_state_nxt == RETURN);
      r_in_handler    <= (w_state_nxt == DISPATCH) || (w_state_nxt == HANDLER) ||
                         (w_state_nxt == RETURN);
      r_stall         <= (w_state_nxt == FETCH) || (w_state_nxt == WAIT) ||
                         (w_state_nxt == DISPATCH);
    end
  end

  assign vec_bus.vec_rd_req = r_vec_rd_req;
  assign vec_bus.vec_addr   = r_vec_addr;
  assign o_trap_pc          = r_trap_pc;
  assign o_trap_pc_valid    = r_trap_pc_valid;
  assign o_ret_pc_valid     = r_ret_pc_valid;
  assign o_epc              = r_epc;
  assign o_cause            = r_cause;
  assign o_in_handler       = r_in_handler;
  assign o_stall            = r_stall;

endmodule
